seg7_scan_driver: RTL
=====================

# seg7_scan_driver

Time-multiplexed six-digit seven-segment driver: the display end of the 4-bit digit-code bus produced by the scrolling-message and timer blocks. It takes six 4-bit codes with a load strobe and double-buffers them so updates take effect only at frame boundaries, which prevents tearing. It scans one digit at a time and decodes each code into active-low segment and anode drive for the board's common-anode displays.

## Interface
- REFRESH_DIV_LOG2, 10: log2 of clocks per digit slot; legal range ≥4.
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- d0..d5  in  4 each  digit codes; d0 is the rightmost digit. Codes: 0–9 numerals, 10 G, 11 b, 12 U, 13 F, 14 S, 15 blank.
- load  in  1  single-cycle strobe that captures d0..d5.
- dim  in  3  brightness, 7 = full. Present only with SEG7_DIM_EN.
- seg  out  7  {g,f,e,d,c,b,a}, active-low, registered.
- an  out  6  digit enables, active-low, bit i = digit i, registered.
- frame  out  1  one-cycle pulse at each frame start, registered.

## Operation
- Prescaler p, REFRESH_DIV_LOG2 bits, free-running and wrapping. tick = (p == all-ones).
- Digit index idx runs 0..5. On tick, idx advances; at idx==5 it wraps to 0. Non-tick cycles hold idx.
- Frame boundary is a tick while idx==5. On the cycle after the boundary, frame=1 and idx=0.
- Buffers:
  - pending[6] plus pend flag; active[6].
  - load captures d0..d5 into pending and sets pend. A second load before the boundary overwrites pending; the last load wins.
  - At a boundary with pend=1, active ← pending and pend is cleared.
  - If load coincides with a boundary, active ← d0..d5 directly and pend stays clear.
  - With no pend at a boundary, active holds.
- Output register, computed from the current idx and p:
  - seg ← glyph(active[idx]).
  - an ← 6'h3F if p==0 (one-cycle ghost guard); otherwise ~(1<<idx).
- Glyph table, hex: 0 40, 1 79, 2 24, 3 30, 4 19, 5 12, 6 02, 7 78, 8 00, 9 10, G 42, b 03, U 41, F 0E, S 12, blank 7F.
- Reset values:
  - p=0, idx=0, pend=0.
  - active and pending all 15 (blank).
  - seg=7'h7F, an=6'h3F, frame=0.
- Asserting rst mid-frame forces all reset values immediately; the scan restarts at digit 0 after release.

## Timing
- seg, an and frame lag idx/p by exactly one clock.
- Slot length is 2^REFRESH_DIV_LOG2 clocks: one guard cycle with anodes off, then the rest of the slot with the digit lit.
- Frame length is 6·2^REFRESH_DIV_LOG2 clocks. frame pulses once per frame.
- Load-to-display latency:
  - Data appears in the first slot after the next frame boundary.
  - Worst case is one frame plus one clock.
- load is sampled every cycle with no busy state; it is never refused.

## Configuration
- SEG7_DIM_EN defined:
  - Adds the dim port.
  - Within each slot, an is driven only when p≠0 and p[top 3 bits] ≤ dim; otherwise an is 6'h3F.
  - seg is unaffected.
- SEG7_DIM_EN undefined:
  - No dim port.
  - Behaviour is identical to dim=7: full slot minus the guard cycle.

## Structure
- Package seg7_pkg holds:
  - NUM_DIGITS=6.
  - Code constants CODE_G=10, CODE_B=11, CODE_U=12, CODE_F=13, CODE_S=14, CODE_BLANK=15.
  - The 16-entry segment pattern constants.
- One combinational sub-module, seg7_glyph_rom: 4-bit code in, 7-bit active-low pattern out, built from the package constants.
- All sequential logic lives in seg7_scan_driver.

## Test plan
All cases use REFRESH_DIV_LOG2=4: 16-cycle slot, 96-cycle frame.
- Reset and release:
  - seg=7F, an=3F immediately.
  - First frame shows blank on every digit.
  - frame pulses at cycle 96 after release.
- Scan order: with no load, an steps 3E, 3D, 3B, 37, 2F, 1F. Each value lasts 15 cycles after a 1-cycle 3F guard, and the sequence repeats every 96 cycles.
- Mid-frame load of codes 0..5:
  - Display stays blank until the frame pulse.
  - Next frame shows digit0 seg=40, digit1 79, digit2 24, digit3 30, digit4 19, digit5 12.
- Load 10,0,15,11,12,13, then a second load 14,14,14,14,14,14 in the same frame: only S (seg=12) is shown on all digits. A load coinciding with the idx5 tick is shown in the very next frame.
- Async reset asserted mid-slot on digit 3: outputs return to 7F/3F within the same cycle, active is blanked, and the scan restarts at digit 0.
- Brightness:
  - With SEG7_DIM_EN and dim=3: each digit is lit for 7 cycles per slot (p=1..7).
  - dim=7: 15 cycles.
  - Without the macro: 15 cycles.

Source files
------------

// File: rtl/seg7_pkg.sv
// Shared constants for the six-digit seven-segment scan driver.
// Segment patterns are {g,f,e,d,c,b,a}, active-low (0 = segment lit).
// Optional brightness control is enabled by defining SEG7_DIM_EN.
package seg7_pkg;

  localparam int NUM_DIGITS = 6;

  typedef logic [3:0] code_t;
  typedef logic [6:0] pattern_t;

  // Digit codes above the numerals
  localparam code_t CODE_G     = 4'd10;
  localparam code_t CODE_B     = 4'd11;
  localparam code_t CODE_U     = 4'd12;
  localparam code_t CODE_F     = 4'd13;
  localparam code_t CODE_S     = 4'd14;
  localparam code_t CODE_BLANK = 4'd15;

  // Segment patterns, one per code
  localparam pattern_t SEG_0     = 7'h40;
  localparam pattern_t SEG_1     = 7'h79;
  localparam pattern_t SEG_2     = 7'h24;
  localparam pattern_t SEG_3     = 7'h30;
  localparam pattern_t SEG_4     = 7'h19;
  localparam pattern_t SEG_5     = 7'h12;
  localparam pattern_t SEG_6     = 7'h02;
  localparam pattern_t SEG_7     = 7'h78;
  localparam pattern_t SEG_8     = 7'h00;
  localparam pattern_t SEG_9     = 7'h10;
  localparam pattern_t SEG_G     = 7'h42;
  localparam pattern_t SEG_B     = 7'h03;
  localparam pattern_t SEG_U     = 7'h41;
  localparam pattern_t SEG_F     = 7'h0E;
  localparam pattern_t SEG_S     = 7'h12;
  localparam pattern_t SEG_BLANK = 7'h7F;

  // All anodes off (active-low)
  localparam logic [NUM_DIGITS-1:0] AN_OFF = 6'h3F;

  // Map a digit code to its active-low segment pattern.
  function automatic pattern_t glyph_of(input code_t code);
    pattern_t pat;
    case (code)
      4'd0:       pat = SEG_0;
      4'd1:       pat = SEG_1;
      4'd2:       pat = SEG_2;
      4'd3:       pat = SEG_3;
      4'd4:       pat = SEG_4;
      4'd5:       pat = SEG_5;
      4'd6:       pat = SEG_6;
      4'd7:       pat = SEG_7;
      4'd8:       pat = SEG_8;
      4'd9:       pat = SEG_9;
      CODE_G:     pat = SEG_G;
      CODE_B:     pat = SEG_B;
      CODE_U:     pat = SEG_U;
      CODE_F:     pat = SEG_F;
      CODE_S:     pat = SEG_S;
      default:    pat = SEG_BLANK;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/seg7_glyph_rom.sv
// Combinational code-to-segment decoder for the scan driver.
module seg7_glyph_rom
  import seg7_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Pure table lookup; registered by the caller.
  always_comb begin
    pattern = glyph_of(code);
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Six-digit time-multiplexed seven-segment driver with frame-synchronous
// double buffering of the digit codes.
// Optional brightness control (dim port) is enabled by defining SEG7_DIM_EN.
//
// load handshake: load is a single-cycle strobe sampled on every clock edge.
// There is no ready/busy signal; a load is never refused. Codes captured
// mid-frame wait in the pending buffer and become visible at the next frame
// boundary; a later load in the same frame replaces them.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  // log2 of clocks per digit slot; must be at least 4 so the three
  // brightness bits and the guard cycle fit in the slot.
  parameter int REFRESH_DIV_LOG2 = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] d0,
  input  logic [3:0] d1,
  input  logic [3:0] d2,
  input  logic [3:0] d3,
  input  logic [3:0] d4,
  input  logic [3:0] d5,
  input  logic       load,
`ifdef SEG7_DIM_EN
  input  logic [2:0] dim,
`endif
  output logic [6:0] seg,
  output logic [5:0] an,
  output logic       frame
);

  localparam int PW = REFRESH_DIV_LOG2;
  localparam logic [2:0] LAST_IDX = 3'(NUM_DIGITS - 1);

  logic [PW-1:0] p;
  logic [2:0]    idx;
  logic          tick;
  logic          boundary;
  logic          pend;
  logic [3:0]    pending [NUM_DIGITS];
  logic [3:0]    active  [NUM_DIGITS];
  logic [3:0]    d_in    [NUM_DIGITS];
  logic [3:0]    cur_code;
  logic [6:0]    cur_pattern;
  logic          lit;
  logic [5:0]    an_next;

  // Gather the input codes into an array so buffers can be loaded in a loop.
  always_comb begin
    d_in[0] = d0;
    d_in[1] = d1;
    d_in[2] = d2;
    d_in[3] = d3;
    d_in[4] = d4;
    d_in[5] = d5;
  end

  assign tick     = &p;
  assign boundary = tick && (idx == LAST_IDX);

  // Free-running prescaler that sets the digit slot length.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p <= '0;
    end else begin
      p <= p + 1'b1;
    end
  end

  // Digit index advances once per slot and wraps after the leftmost digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx <= '0;
    end else if (tick) begin
      idx <= (idx == LAST_IDX) ? 3'd0 : idx + 3'd1;
    end
  end

  // Pending buffer: every load lands here unless it coincides with the
  // frame boundary, in which case it goes straight to the active buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend <= 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pending[i] <= CODE_BLANK;
      end
    end else if (load && !boundary) begin
      pend <= 1'b1;
      for (int i = 0; i < NUM_DIGITS; i++) begin
        pending[i] <= d_in[i];
      end
    end else if (boundary) begin
      pend <= 1'b0;
    end
  end

  // Active buffer only changes at a frame boundary, so a frame never mixes
  // old and new codes. A coincident load takes priority over pending data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= CODE_BLANK;
      end
    end else if (boundary && load) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= d_in[i];
      end
    end else if (boundary && pend) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        active[i] <= pending[i];
      end
    end
  end

  // Select the code of the digit currently being scanned.
  always_comb begin
    cur_code = CODE_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == 3'(i)) begin
        cur_code = active[i];
      end
    end
  end

  seg7_glyph_rom u_glyph_rom (
    .code    (cur_code),
    .pattern (cur_pattern)
  );

  // Anode drive: the first cycle of each slot is a blanking guard so the
  // previous digit's segments never ghost onto the next digit.
  always_comb begin
    lit = (p != '0);
`ifdef SEG7_DIM_EN
    if (p[PW-1 -: 3] > dim) begin
      lit = 1'b0;
    end
`endif
    an_next = AN_OFF;
    if (lit) begin
      an_next = ~(6'b1 << idx);
    end
  end

  // Output register: everything the board sees lags idx/p by one clock.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seg   <= SEG_BLANK;
      an    <= AN_OFF;
      frame <= 1'b0;
    end else begin
      seg   <= cur_pattern;
      an    <= an_next;
      frame <= boundary;
    end
  end

endmodule
